// File: rtl/xor4_parity_rx.sv
// Serial receiver for the 4-bit parity link: deserialises a,b,c,d,p frames,
// checks parity, strobes the recovered nibble and counts parity errors.
module xor4_parity_rx #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_valid,
  input  logic             i_sync,
  input  logic             i_clr_cnt,
  output logic [3:0]       o_data,
  output logic             o_valid,
  output logic             o_par_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_busy
);

  typedef enum logic [2:0] {S_A, S_B, S_C, S_D, S_P} state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [3:0]       sh_q, sh_d;
  logic [3:0]       data_q;
  logic             valid_q, perr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             frame_done, err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_A;
      acc_q   <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    frame_done = 1'b0;
    err        = 1'b0;
    if (i_sync) begin
      // Resync drops the partial frame; a coincident bit starts the new one.
      state_d = S_A;
      acc_d   = 1'b0;
      if (i_valid) begin
        state_d = S_B;
        acc_d   = i_bit;
        sh_d    = {sh_q[2:0], i_bit};
      end
    end else if (i_valid) begin
      case (state_q)
        S_A: begin
          state_d = S_B;
          acc_d   = i_bit;
          sh_d    = {sh_q[2:0], i_bit};
        end
        S_B: begin
          state_d = S_C;
          acc_d   = acc_q ^ i_bit;
          sh_d    = {sh_q[2:0], i_bit};
        end
        S_C: begin
          state_d = S_D;
          acc_d   = acc_q ^ i_bit;
          sh_d    = {sh_q[2:0], i_bit};
        end
        S_D: begin
          state_d = S_P;
          acc_d   = acc_q ^ i_bit;
          sh_d    = {sh_q[2:0], i_bit};
        end
        S_P: begin
          state_d    = S_A;
          frame_done = 1'b1;
          err        = acc_q ^ i_bit ^ ODD_PARITY;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= frame_done;
      perr_q  <= frame_done & err;
      if (frame_done) data_q <= sh_q;
    end
  end

  // Counter advances at the end of the strobe cycle so a clear in that same
  // cycle overrides the increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr_cnt) begin
      cnt_q <= '0;
    end else if (valid_q && perr_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_par_err = perr_q;
  assign o_err_cnt = cnt_q;
  assign o_busy    = (state_q != S_A);

endmodule
